// File: rtl/fusion_pkg.sv
// Shared definitions for the layer scheduler: op codes, DMA direction,
// command word field positions and the scheduler state encoding.
package fusion_pkg;

  typedef enum logic [1:0] {
    OP_CONV    = 2'd0,
    OP_MAXPOOL = 2'd1,
    OP_AVGPOOL = 2'd2,
    OP_END     = 2'd3
  } op_e;

  localparam logic DMA_LOAD  = 1'b0;
  localparam logic DMA_STORE = 1'b1;

  localparam int CMD_OP_HI = 31;
  localparam int CMD_OP_LO = 30;
  localparam int CMD_SKIP  = 29;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOAD       = 4'd1,
    ST_LOAD_WAIT  = 4'd2,
    ST_EXEC       = 4'd3,
    ST_EXEC_WAIT  = 4'd4,
    ST_STORE      = 4'd5,
    ST_STORE_WAIT = 4'd6,
    ST_DONE       = 4'd7,
    ST_ERR        = 4'd8
  } state_e;

  // True for the states that wait on an engine completion pulse.
  function automatic logic is_wait(input state_e st);
    logic res;
    case (st)
      ST_LOAD_WAIT, ST_EXEC_WAIT, ST_STORE_WAIT: res = 1'b1;
      default:                                   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sched_wdog.sv
// Watchdog for the scheduler wait states. Cleared on entry to a wait state,
// counts while enabled; timeout flags the last cycle before the count
// would reach 2^WDOG_W-1, so the wait lasts 2^WDOG_W-1 cycles at most.
module sched_wdog #(
  parameter int WDOG_W = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [WDOG_W-1:0] LAST = {{(WDOG_W-1){1'b1}}, 1'b0};
  localparam logic [WDOG_W-1:0] ONE  = WDOG_W'(1'b1);

  logic [WDOG_W-1:0] cnt_r;

  // Cycle counter: clear has priority, counting saturates at the terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign timeout = en && (cnt_r == LAST);

endmodule

// File: rtl/layer_sched.sv
// Layer command scheduler: per command runs DMA load, conv or pool, then an
// optional DMA store; counts finished layers, raises irq at end of network
// or on a hung/stray engine. All outputs are registered from the next state.
module layer_sched
  import fusion_pkg::*;
#(
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 8,
  parameter int WDOG_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_data,
  output logic [1:0]       op_type,
  output logic             dma_valid,
  output logic             dma_dir,
  output logic [LEN_W-1:0] dma_len,
  input  logic             dma_ready,
  output logic             conv_valid,
  input  logic             conv_ready,
  output logic             pool_valid,
  input  logic             pool_ready,
  output logic             irq,
  input  logic             irq_ack,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] layer_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  state_e state_r, state_nx_s;
  op_e    op_r;
  logic   skip_r;
  logic   accept_s, layer_done_s, ack_s;
  logic   eng_ready_s, other_ready_s;
  logic   wd_clr_s, wd_en_s, wd_to_s;
  logic   unused_cmd_bits_s;

  // Bits between the skip flag and the length field carry nothing.
  assign unused_cmd_bits_s = ^cmd_data[CMD_SKIP-1:LEN_W];

  sched_wdog #(.WDOG_W(WDOG_W)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr_s),
    .en      (wd_en_s),
    .timeout (wd_to_s)
  );

  // Next-state logic; a stray completion beats the awaited one, and the
  // awaited one beats a watchdog timeout on the same cycle.
  always_comb begin
    state_nx_s    = state_r;
    accept_s      = 1'b0;
    layer_done_s  = 1'b0;
    ack_s         = 1'b0;
    eng_ready_s   = (op_r == OP_CONV) ? conv_ready : pool_ready;
    other_ready_s = (op_r == OP_CONV) ? pool_ready : conv_ready;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept_s = 1'b1;
          if (cmd_data[CMD_OP_HI:CMD_OP_LO] == OP_END) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_LOAD;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD:  state_nx_s = ST_LOAD_WAIT;
      ST_EXEC:  state_nx_s = ST_EXEC_WAIT;
      ST_STORE: state_nx_s = ST_STORE_WAIT;
      ST_LOAD_WAIT, ST_STORE_WAIT: begin
        if (conv_ready || pool_ready) begin
          state_nx_s = ST_ERR;
        end else if (dma_ready) begin
          if (state_r == ST_LOAD_WAIT) begin
            state_nx_s = ST_EXEC;
          end else begin
            state_nx_s   = ST_IDLE;
            layer_done_s = 1'b1;
          end
        end else if (wd_to_s) begin
          state_nx_s = ST_ERR;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_EXEC_WAIT: begin
        if (other_ready_s || dma_ready) begin
          state_nx_s = ST_ERR;
        end else if (eng_ready_s) begin
          if (skip_r) begin
            state_nx_s   = ST_IDLE;
            layer_done_s = 1'b1;
          end else begin
            state_nx_s = ST_STORE;
          end
        end else if (wd_to_s) begin
          state_nx_s = ST_ERR;
        end else begin
          state_nx_s = ST_EXEC_WAIT;
        end
      end
      ST_DONE, ST_ERR: begin
        if (irq_ack) begin
          state_nx_s = ST_IDLE;
          ack_s      = 1'b1;
        end else begin
          state_nx_s = state_r;
        end
      end
      default: state_nx_s = ST_ERR;
    endcase
    wd_en_s  = is_wait(state_r);
    wd_clr_s = is_wait(state_nx_s) && (state_nx_s != state_r);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Capture the command fields at the handshake; held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= OP_CONV;
      skip_r  <= 1'b0;
      op_type <= 2'd0;
      dma_len <= '0;
    end else if (accept_s) begin
      op_r    <= op_e'(cmd_data[CMD_OP_HI:CMD_OP_LO]);
      skip_r  <= cmd_data[CMD_SKIP];
      op_type <= cmd_data[CMD_OP_HI:CMD_OP_LO];
      dma_len <= cmd_data[LEN_W-1:0];
    end else begin
      op_r    <= op_r;
      skip_r  <= skip_r;
      op_type <= op_type;
      dma_len <= dma_len;
    end
  end

  // Registered handshake, start pulses and status decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready  <= 1'b0;
      dma_valid  <= 1'b0;
      dma_dir    <= DMA_LOAD;
      conv_valid <= 1'b0;
      pool_valid <= 1'b0;
      busy       <= 1'b0;
      irq        <= 1'b0;
      err        <= 1'b0;
    end else begin
      cmd_ready  <= (state_nx_s == ST_IDLE);
      dma_valid  <= (state_nx_s == ST_LOAD) || (state_nx_s == ST_STORE);
      conv_valid <= (state_nx_s == ST_EXEC) && (op_r == OP_CONV);
      pool_valid <= (state_nx_s == ST_EXEC) && (op_r != OP_CONV);
      busy       <= (state_nx_s != ST_IDLE);
      irq        <= (state_nx_s == ST_DONE) || (state_nx_s == ST_ERR);
      err        <= (state_nx_s == ST_ERR);
      if (state_nx_s == ST_LOAD) begin
        dma_dir <= DMA_LOAD;
      end else if (state_nx_s == ST_STORE) begin
        dma_dir <= DMA_STORE;
      end else begin
        dma_dir <= dma_dir;
      end
    end
  end

  // Completed-layer counter; wraps silently, cleared by the host acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_cnt <= '0;
    end else if (ack_s) begin
      layer_cnt <= '0;
    end else if (layer_done_s) begin
      layer_cnt <= layer_cnt + CNT_ONE;
    end else begin
      layer_cnt <= layer_cnt;
    end
  end

endmodule

// File: tb/tb_layer_sched.sv
// Self-checking bench for layer_sched. The bench plays host and engines;
// inputs change on the falling edge and outputs are checked there too.
module tb_layer_sched;

  localparam int LEN_W  = 16;
  localparam int CNT_W  = 4;
  localparam int WDOG_W = 4;
  localparam int CNT_MOD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic [31:0] cmd_data = 32'd0;
  logic dma_ready = 1'b0, conv_ready = 1'b0, pool_ready = 1'b0, irq_ack = 1'b0;
  logic cmd_ready, dma_valid, dma_dir, conv_valid, pool_valid, irq, busy, err;
  logic [1:0] op_type;
  logic [LEN_W-1:0] dma_len;
  logic [CNT_W-1:0] layer_cnt;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  layer_sched #(.LEN_W(LEN_W), .CNT_W(CNT_W), .WDOG_W(WDOG_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .op_type(op_type), .dma_valid(dma_valid),
    .dma_dir(dma_dir), .dma_len(dma_len), .dma_ready(dma_ready),
    .conv_valid(conv_valid), .conv_ready(conv_ready), .pool_valid(pool_valid),
    .pool_ready(pool_ready), .irq(irq), .irq_ack(irq_ack), .busy(busy),
    .err(err), .layer_cnt(layer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Engine completion: wait lat cycles inside the wait state, then one pulse.
  // which: 0 dma, 1 conv, 2 pool.
  task automatic pulse_ready(input int which, input int lat);
    repeat (lat + 1) step();
    dma_ready  = (which == 0);
    conv_ready = (which == 1);
    pool_ready = (which == 2);
    step();
    dma_ready = 1'b0; conv_ready = 1'b0; pool_ready = 1'b0;
  endtask

  // Present a command and hold it until the handshake edge has passed.
  task automatic send(input logic [1:0] op, input logic skip, input logic [15:0] len);
    logic got;
    got = 1'b0;
    cmd_data  = {op, skip, 13'd0, len};
    cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      got = cmd_ready;
      step();
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", {31'd0, got}, 32'd1);
  endtask

  // One full layer; the reference is the load / exec / optional store rule.
  task automatic run_layer(input logic [1:0] op, input logic skip, input logic [15:0] len,
                           input int l1, input int l2, input int l3);
    send(op, skip, len);
    chk("load_valid", {31'd0, dma_valid}, 32'd1);
    chk("load_dir",   {31'd0, dma_dir},   32'd0);
    chk("load_len",   {16'd0, dma_len},   {16'd0, len});
    chk("op_type",    {30'd0, op_type},   {30'd0, op});
    chk("busy_run",   {31'd0, busy},      32'd1);
    chk("ready_busy", {31'd0, cmd_ready}, 32'd0);
    pulse_ready(0, l1);
    chk("conv_start", {31'd0, conv_valid}, {31'd0, (op == 2'd0)});
    chk("pool_start", {31'd0, pool_valid}, {31'd0, (op != 2'd0)});
    pulse_ready((op == 2'd0) ? 1 : 2, l2);
    if (!skip) begin
      chk("store_valid", {31'd0, dma_valid}, 32'd1);
      chk("store_dir",   {31'd0, dma_dir},   32'd1);
      pulse_ready(0, l3);
    end
    exp_cnt = (exp_cnt + 1) % CNT_MOD;
    chk("idle_busy", {31'd0, busy},      32'd0);
    chk("layer_cnt", {28'd0, layer_cnt}, exp_cnt);
    chk("idle_err",  {31'd0, err},       32'd0);
  endtask

  // End-of-network command, then acknowledge.
  task automatic end_and_ack();
    send(2'd3, 1'b0, 16'd0);
    chk("done_irq",  {31'd0, irq},       32'd1);
    chk("done_busy", {31'd0, busy},      32'd1);
    chk("done_cnt",  {28'd0, layer_cnt}, exp_cnt);
    repeat (3) step();
    chk("done_hold", {31'd0, irq},       32'd1);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    exp_cnt = 0;
    chk("ack_irq",   {31'd0, irq},       32'd0);
    chk("ack_cnt",   {28'd0, layer_cnt}, 32'd0);
    chk("ack_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  // Expect the error state, then acknowledge it.
  task automatic err_and_ack(input string tag);
    chk({tag, "_err"}, {31'd0, err}, 32'd1);
    chk({tag, "_irq"}, {31'd0, irq}, 32'd1);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    exp_cnt = 0;
    chk({tag, "_clr"}, {30'd0, err, irq}, 32'd0);
    chk({tag, "_cnt"}, {28'd0, layer_cnt}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Reset values
    repeat (2) step();
    chk("rst_outs", {cmd_ready, dma_valid, conv_valid, pool_valid, irq, busy, err, dma_dir}, 8'd0);
    chk("rst_regs", {op_type, dma_len, layer_cnt}, 22'd0);
    rst_n = 1'b1;
    repeat (2) step();
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Conv with store, len 64
    run_layer(2'd0, 1'b0, 16'h0040, 2, 3, 1);
    // Maxpool without store, then end of network
    run_layer(2'd1, 1'b1, 16'h0010, 0, 4, 0);
    end_and_ack();

    // irq_ack outside DONE/ERR has no effect
    run_layer(2'd2, 1'b0, 16'h1234, 1, 1, 1);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("stray_ack_cnt", {28'd0, layer_cnt}, exp_cnt);
    chk("stray_ack_irq", {31'd0, irq}, 32'd0);

    // Randomized layers; counter wraps past 2^CNT_W
    for (int n = 0; n < 20; n++) begin
      run_layer(2'($urandom_range(2, 0)), 1'($urandom_range(1, 0)), 16'($urandom),
                $urandom_range(5, 0), $urandom_range(5, 0), $urandom_range(5, 0));
    end
    end_and_ack();

    // Watchdog: conv never completes, 15 cycles in the wait then error
    send(2'd0, 1'b0, 16'd7);
    pulse_ready(0, 0);
    chk("wd_conv_start", {31'd0, conv_valid}, 32'd1);
    repeat (15) step();
    chk("wd_not_yet", {30'd0, err, irq}, 32'd0);
    step();
    chk("wd_busy", {31'd0, busy}, 32'd1);
    err_and_ack("wd");

    // Completion on the terminal cycle wins over the watchdog
    send(2'd0, 1'b1, 16'd9);
    pulse_ready(0, 0);
    pulse_ready(1, 14);
    exp_cnt = 1;
    chk("wd_term_err",  {31'd0, err},  32'd0);
    chk("wd_term_busy", {31'd0, busy}, 32'd0);
    chk("wd_term_cnt",  {28'd0, layer_cnt}, exp_cnt);

    // Stray pool completion while waiting for conv
    send(2'd0, 1'b0, 16'd3);
    pulse_ready(0, 1);
    pulse_ready(2, 1);
    err_and_ack("stray_pool");

    // DMA completion together with the awaited pool completion
    send(2'd2, 1'b0, 16'd3);
    pulse_ready(0, 1);
    step(); step();
    dma_ready = 1'b1; pool_ready = 1'b1; step();
    dma_ready = 1'b0; pool_ready = 1'b0;
    err_and_ack("coincide");

    // Backpressure: command valid held across a whole command
    cmd_data = {2'd0, 1'b0, 13'd0, 16'd5};
    cmd_valid = 1'b1;
    chk("bp_ready0", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_data = {2'd1, 1'b1, 13'd0, 16'd77};
    chk("bp_first_len", {16'd0, dma_len}, 32'd5);
    pulse_ready(0, 1);
    chk("bp_hold_exec", {31'd0, cmd_ready}, 32'd0);
    pulse_ready(1, 1);
    chk("bp_hold_store", {31'd0, cmd_ready}, 32'd0);
    pulse_ready(0, 1);
    exp_cnt = exp_cnt + 1;
    chk("bp_idle_ready", {31'd0, cmd_ready}, 32'd1);
    chk("bp_cnt1", {28'd0, layer_cnt}, exp_cnt);
    step();
    cmd_valid = 1'b0;
    chk("bp_second_len", {16'd0, dma_len}, 32'd77);
    chk("bp_second_valid", {31'd0, dma_valid}, 32'd1);
    pulse_ready(0, 0);
    pulse_ready(2, 0);
    exp_cnt = exp_cnt + 1;
    repeat (3) step();
    chk("bp_once_busy", {31'd0, busy}, 32'd0);
    chk("bp_cnt2", {28'd0, layer_cnt}, exp_cnt);

    // Reset while waiting on the store DMA
    send(2'd0, 1'b0, 16'd8);
    pulse_ready(0, 0);
    pulse_ready(1, 0);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {cmd_ready, dma_valid, conv_valid, pool_valid, irq, busy, err, dma_dir}, 8'd0);
    chk("mid_rst_regs", {op_type, dma_len, layer_cnt}, 22'd0);
    step();
    rst_n = 1'b1;
    exp_cnt = 0;
    dma_ready = 1'b1; step(); dma_ready = 1'b0;
    step();
    chk("late_ready_err", {30'd0, err, busy}, 32'd0);
    chk("late_ready_cnt", {28'd0, layer_cnt}, 32'd0);
    run_layer(2'd0, 1'b0, 16'h00ab, 1, 2, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
